axi_rd_arbiter: RTL and testbench

- Two-master, one-slave AXI read-channel arbiter placed between the instruction-fetch and data-memory refill paths and the top-level AXI read ports (ar*/r*).
- Round-robin grant.
- One outstanding burst at a time; the R beats of that burst are routed only to its owner.
- Tracks a beat counter and flags a sticky protocol error when rlast disagrees with the granted arlen.

---
 rtl/axi_pkg.sv | 25 ++
 rtl/axi_rd_arbiter_if.sv | 57 +++++
 rtl/rr_arbiter2.sv | 21 ++
 rtl/axi_rd_arbiter.sv | 133 +++++++++++++
 tb/tb_axi_rd_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared definitions for the AXI read-channel arbiter slice.
//   AXI_BURST_INCR : arburst encoding driven on every request
//   M0_ID_DEF/M1_ID_DEF : default arid values for the two masters
//   ar_req_t : latched read-address request (addr/len/size/id)
//   state_t  : arbiter FSM states
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] M0_ID_DEF      = 4'd0;
  localparam logic [3:0] M1_ID_DEF      = 4'd1;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [3:0]  id;
  } ar_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_t;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Bus bundle for axi_rd_arbiter: both upstream master read ports (m0_*, m1_*)
// and the downstream AXI read channels (ar*, r*).
//   modport master : arbiter view (it masters the downstream AXI port)
//   modport slave  : environment view (upstream masters + AXI slave)
interface axi_rd_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  logic              m0_arvalid, m1_arvalid;
  logic [31:0]       m0_araddr,  m1_araddr;
  logic [7:0]        m0_arlen,   m1_arlen;
  logic [2:0]        m0_arsize,  m1_arsize;
  logic              m0_arready, m1_arready;
  logic [DATA_W-1:0] m0_rdata,   m1_rdata;
  logic [1:0]        m0_rresp,   m1_rresp;
  logic              m0_rlast,   m1_rlast;
  logic              m0_rvalid,  m1_rvalid;
  logic              m0_rready,  m1_rready;

  logic [3:0]        arid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    input  m0_arvalid, m0_araddr, m0_arlen, m0_arsize, m0_rready,
    input  m1_arvalid, m1_araddr, m1_arlen, m1_arsize, m1_rready,
    output m0_arready, m0_rdata, m0_rresp, m0_rlast, m0_rvalid,
    output m1_arready, m1_rdata, m1_rresp, m1_rlast, m1_rvalid,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output m0_arvalid, m0_araddr, m0_arlen, m0_arsize, m0_rready,
    output m1_arvalid, m1_araddr, m1_arlen, m1_arsize, m1_rready,
    input  m0_arready, m0_rdata, m0_rresp, m0_rlast, m0_rvalid,
    input  m1_arready, m1_rdata, m1_rresp, m1_rlast, m1_rvalid,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick.
//   req[1:0]   : request per master
//   last_grant : index of the master served most recently
//   gnt_valid  : at least one request present
//   gnt        : chosen master index (on a tie, the one that was not last served)
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt
);
  always_comb begin
    gnt_valid = |req;
    gnt       = 1'b0;
    case (req)
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_grant;
      default: gnt = 1'b0;
    endcase
  end
endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master, one-slave AXI read arbiter with a single outstanding burst.
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   bus           : m0_*/m1_* master read ports and downstream ar*/r* channels
//   busy          : FSM not in IDLE
//   proto_err     : sticky flag, rlast disagreed with the granted arlen
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter logic [3:0]  M0_ID  = M0_ID_DEF,
  parameter logic [3:0]  M1_ID  = M1_ID_DEF,
  parameter int unsigned DATA_W = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  axi_rd_arbiter_if.master bus,
  output logic             busy,
  output logic             proto_err
);
  localparam logic [DATA_W-1:0] RDATA_ZERO = '0;

  state_t     state, state_nxt;
  logic       grant, last_grant;
  logic [7:0] beat_cnt;
  ar_req_t    req_q, req_pick;
  logic       pick_valid, pick;
  logic       sel_rready;
  logic       rhs;
  logic       unused_rid;

  rr_arbiter2 u_rr (
    .req        ({bus.m1_arvalid, bus.m0_arvalid}),
    .last_grant (last_grant),
    .gnt_valid  (pick_valid),
    .gnt        (pick)
  );

  always_comb begin
    if (pick) req_pick = '{addr: bus.m1_araddr, len: bus.m1_arlen, size: bus.m1_arsize, id: M1_ID};
    else      req_pick = '{addr: bus.m0_araddr, len: bus.m0_arlen, size: bus.m0_arsize, id: M0_ID};
  end

  // Handshake computed outside the FSM block so rready does not feed back into it.
  assign sel_rready = grant ? bus.m1_rready : bus.m0_rready;
  assign rhs        = (state == R) && bus.rvalid && sel_rready;
  assign unused_rid = ^bus.rid;

  assign bus.arid    = req_q.id;
  assign bus.araddr  = req_q.addr;
  assign bus.arlen   = req_q.len;
  assign bus.arsize  = req_q.size;
  assign bus.arburst = AXI_BURST_INCR;
  assign bus.arlock  = '0;
  assign bus.arcache = '0;
  assign bus.arprot  = '0;
  assign busy        = (state != IDLE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.m0_arready = 1'b0;
    bus.m1_arready = 1'b0;
    bus.arvalid    = 1'b0;
    bus.rready     = 1'b0;
    bus.m0_rvalid  = 1'b0;
    bus.m0_rdata   = RDATA_ZERO;
    bus.m0_rresp   = '0;
    bus.m0_rlast   = 1'b0;
    bus.m1_rvalid  = 1'b0;
    bus.m1_rdata   = RDATA_ZERO;
    bus.m1_rresp   = '0;
    bus.m1_rlast   = 1'b0;
    case (state)
      IDLE: begin
        // aresetn gate keeps the accept pulse low while reset is held.
        if (pick_valid && aresetn) begin
          state_nxt = AR;
          if (pick) bus.m1_arready = 1'b1;
          else      bus.m0_arready = 1'b1;
        end
      end
      AR: begin
        bus.arvalid = 1'b1;
        if (bus.arready) state_nxt = R;
      end
      R: begin
        bus.rready = sel_rready;
        if (grant) begin
          bus.m1_rvalid = bus.rvalid;
          bus.m1_rdata  = bus.rdata;
          bus.m1_rresp  = bus.rresp;
          bus.m1_rlast  = bus.rlast;
        end else begin
          bus.m0_rvalid = bus.rvalid;
          bus.m0_rdata  = bus.rdata;
          bus.m0_rresp  = bus.rresp;
          bus.m0_rlast  = bus.rlast;
        end
        if (rhs && bus.rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
      proto_err  <= 1'b0;
      req_q      <= '0;
    end else begin
      if (state == IDLE && pick_valid) begin
        grant    <= pick;
        req_q    <= req_pick;
        beat_cnt <= '0;
      end
      if (rhs) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (bus.rlast) begin
          last_grant <= grant;
          if (beat_cnt != req_q.len) proto_err <= 1'b1;
        end else if (beat_cnt == req_q.len) begin
          proto_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic busy, perr;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_exp_t;

  typedef struct {
    int          m;
    logic [31:0] data;
    logic        last;
    logic [1:0]  resp;
  } beat_exp_t;

  ar_exp_t   arq[$];
  beat_exp_t bq[$];

  always #5 clk = ~clk;

  axi_rd_arbiter_if #(.DATA_W(32)) bus ();

  axi_rd_arbiter #(
    .M0_ID  (4'd0),
    .M1_ID  (4'd1),
    .DATA_W (32)
  ) dut (
    .aclk      (clk),
    .aresetn   (rstn),
    .bus       (bus.master),
    .busy      (busy),
    .proto_err (perr)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic issue(input int m, input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    ar_exp_t e;
    e.id = (m == 1) ? 4'd1 : 4'd0;
    e.addr = a; e.len = l; e.size = s;
    arq.push_back(e);
    if (m == 1) begin
      bus.m1_arvalid = 1'b1; bus.m1_araddr = a; bus.m1_arlen = l; bus.m1_arsize = s;
    end else begin
      bus.m0_arvalid = 1'b1; bus.m0_araddr = a; bus.m0_arlen = l; bus.m0_arsize = s;
    end
  endtask

  // Waits (bounded) for the accept pulse, checks who got it, then drops that request.
  task automatic grant_check(input int m);
    bit found = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.m0_arready || bus.m1_arready) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      chk("grant_timeout", 64'd0, 64'd1);
      return;
    end
    chk("grant_m1_arready", bus.m1_arready, (m == 1));
    chk("grant_m0_arready", bus.m0_arready, (m == 0));
    @(negedge clk);
    if (m == 1) bus.m1_arvalid = 1'b0;
    else        bus.m0_arvalid = 1'b0;
  endtask

  task automatic ar_phase(input int stall);
    ar_exp_t e;
    if (arq.size() == 0) begin
      chk("ar_queue_empty", 64'd0, 64'd1);
      return;
    end
    e = arq.pop_front();
    bus.arready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      #1;
      chk("ar_stall_arvalid", bus.arvalid, 1'b1);
      chk("ar_stall_araddr", bus.araddr, e.addr);
      chk("ar_stall_arlen", bus.arlen, e.len);
      @(negedge clk);
    end
    bus.arready = 1'b1;
    #1;
    chk("ar_arvalid", bus.arvalid, 1'b1);
    chk("ar_arid", bus.arid, e.id);
    chk("ar_araddr", bus.araddr, e.addr);
    chk("ar_arlen", bus.arlen, e.len);
    chk("ar_arsize", bus.arsize, e.size);
    chk("ar_arburst", bus.arburst, 2'b01);
    @(negedge clk);
    bus.arready = 1'b0;
  endtask

  // One cycle on the R channel; a beat is expected at the master only when rr=1.
  task automatic beat(input int m, input logic [31:0] d, input logic last, input logic rr);
    beat_exp_t e;
    logic [1:0] resp;
    resp = d[1:0];
    bus.rvalid = 1'b1; bus.rdata = d; bus.rlast = last; bus.rresp = resp; bus.rid = 4'hF;
    bus.m0_rready = (m == 0) ? rr : 1'b1;
    bus.m1_rready = (m == 1) ? rr : 1'b1;
    if (rr) begin
      e.m = m; e.data = d; e.last = last; e.resp = resp;
      bq.push_back(e);
    end
    #1;
    chk("r_rready", bus.rready, rr);
    if (m == 1) begin
      chk("r_m1_rvalid", bus.m1_rvalid, 1'b1);
      chk("r_m0_rvalid_off", bus.m0_rvalid, 1'b0);
      chk("r_m0_rdata_off", bus.m0_rdata, 32'd0);
    end else begin
      chk("r_m0_rvalid", bus.m0_rvalid, 1'b1);
      chk("r_m1_rvalid_off", bus.m1_rvalid, 1'b0);
      chk("r_m1_rdata_off", bus.m1_rdata, 32'd0);
    end
    if (rr && bq.size() != 0) begin
      e = bq.pop_front();
      chk("r_rdata", (e.m == 1) ? bus.m1_rdata : bus.m0_rdata, e.data);
      chk("r_rlast", (e.m == 1) ? bus.m1_rlast : bus.m0_rlast, e.last);
      chk("r_rresp", (e.m == 1) ? bus.m1_rresp : bus.m0_rresp, e.resp);
    end
    @(negedge clk);
    bus.rvalid = 1'b0; bus.rlast = 1'b0;
  endtask

  initial begin
    bus.m0_arvalid = 0; bus.m0_araddr = '0; bus.m0_arlen = '0; bus.m0_arsize = '0; bus.m0_rready = 0;
    bus.m1_arvalid = 0; bus.m1_araddr = '0; bus.m1_arlen = '0; bus.m1_arsize = '0; bus.m1_rready = 0;
    bus.arready = 0; bus.rid = '0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 0; bus.rvalid = 0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_arvalid", bus.arvalid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_proto_err", perr, 1'b0);
    chk("rst_m0_arready", bus.m0_arready, 1'b0);
    chk("rst_m1_arready", bus.m1_arready, 1'b0);
    chk("rst_araddr", bus.araddr, 32'd0);
    chk("const_arlock", bus.arlock, 2'd0);
    chk("const_arcache", bus.arcache, 4'd0);
    chk("const_arprot", bus.arprot, 3'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Single m0 request, four beats
    issue(0, 32'h1C00_0000, 8'd3, 3'd2);
    grant_check(0);
    ar_phase(0);
    for (int i = 0; i < 4; i++) beat(0, 32'hA0 + i, (i == 3), 1'b1);
    #1;
    chk("single_busy_after", busy, 1'b0);
    chk("single_proto_err", perr, 1'b0);
    @(negedge clk);

    // Simultaneous requests after reset: m0, m1, m0, m1
    do_reset();
    issue(0, 32'h0000_1000, 8'd0, 3'd2);
    issue(1, 32'h0000_2000, 8'd0, 3'd2);
    grant_check(0);
    ar_phase(0);
    beat(0, 32'hB0, 1'b1, 1'b1);
    grant_check(1);
    ar_phase(0);
    beat(1, 32'hB1, 1'b1, 1'b1);
    issue(0, 32'h0000_3000, 8'd0, 3'd1);
    issue(1, 32'h0000_4000, 8'd0, 3'd1);
    grant_check(0);
    ar_phase(0);
    beat(0, 32'hB2, 1'b1, 1'b1);
    grant_check(1);
    ar_phase(0);
    beat(1, 32'hB3, 1'b1, 1'b1);
    #1;
    chk("rr_busy_after", busy, 1'b0);
    chk("rr_proto_err", perr, 1'b0);
    @(negedge clk);

    // Backpressure: arready low 5 cycles, m1_rready low on 2 beats
    issue(1, 32'h8000_0040, 8'd3, 3'd2);
    grant_check(1);
    // The master changes its request fields; the latched ones must hold.
    bus.m1_araddr = 32'hDEAD_BEEF; bus.m1_arlen = 8'd9;
    ar_phase(5);
    beat(1, 32'hC0, 1'b0, 1'b1);
    beat(1, 32'hC1, 1'b0, 1'b0);
    beat(1, 32'hC1, 1'b0, 1'b1);
    beat(1, 32'hC2, 1'b0, 1'b0);
    beat(1, 32'hC2, 1'b0, 1'b1);
    beat(1, 32'hC3, 1'b1, 1'b1);
    #1;
    chk("bp_beat_cnt", dut.beat_cnt, 8'd4);
    chk("bp_busy_after", busy, 1'b0);
    chk("bp_proto_err", perr, 1'b0);
    @(negedge clk);

    // Early rlast: arlen=3, rlast on beat index 1
    issue(0, 32'h0000_5000, 8'd3, 3'd2);
    grant_check(0);
    ar_phase(0);
    beat(0, 32'hD0, 1'b0, 1'b1);
    beat(0, 32'hD1, 1'b1, 1'b1);
    #1;
    chk("early_last_proto_err", perr, 1'b1);
    chk("early_last_busy", busy, 1'b0);
    @(negedge clk);
    issue(1, 32'h0000_6000, 8'd0, 3'd2);
    grant_check(1);
    ar_phase(0);
    beat(1, 32'hD2, 1'b1, 1'b1);
    #1;
    chk("sticky_proto_err", perr, 1'b1);
    @(negedge clk);

    // Missing rlast on a single-beat burst: error, FSM keeps waiting
    do_reset();
    #1;
    chk("rst_clears_proto_err", perr, 1'b0);
    issue(0, 32'h0000_7000, 8'd0, 3'd2);
    grant_check(0);
    ar_phase(0);
    beat(0, 32'hE0, 1'b0, 1'b1);
    #1;
    chk("late_last_proto_err", perr, 1'b1);
    chk("late_last_busy", busy, 1'b1);
    beat(0, 32'hE1, 1'b1, 1'b1);
    #1;
    chk("late_last_idle", busy, 1'b0);
    @(negedge clk);

    // Spurious beat in IDLE
    do_reset();
    bus.rvalid = 1'b1; bus.rdata = 32'h55; bus.rlast = 1'b1;
    bus.m0_rready = 1'b1; bus.m1_rready = 1'b1;
    #1;
    chk("spur_rready", bus.rready, 1'b0);
    chk("spur_m0_rvalid", bus.m0_rvalid, 1'b0);
    chk("spur_m1_rvalid", bus.m1_rvalid, 1'b0);
    @(negedge clk);
    #1;
    chk("spur_proto_err", perr, 1'b0);
    chk("spur_busy", busy, 1'b0);
    bus.rvalid = 1'b0; bus.rlast = 1'b0;
    @(negedge clk);

    // Reset mid-burst after 2 of 4 beats
    issue(0, 32'h0000_9000, 8'd3, 3'd2);
    grant_check(0);
    ar_phase(0);
    beat(0, 32'hF0, 1'b0, 1'b1);
    beat(0, 32'hF1, 1'b0, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_arvalid", bus.arvalid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    bus.rvalid = 1'b1; bus.rdata = 32'hF2; bus.rlast = 1'b0; bus.m0_rready = 1'b1;
    #1;
    chk("midrst_drop_rready", bus.rready, 1'b0);
    chk("midrst_drop_m0_rvalid", bus.m0_rvalid, 1'b0);
    @(negedge clk);
    bus.rvalid = 1'b0;
    issue(1, 32'h0000_A000, 8'd0, 3'd2);
    grant_check(1);
    ar_phase(0);
    beat(1, 32'hF9, 1'b1, 1'b1);
    #1;
    chk("midrst_after_busy", busy, 1'b0);
    chk("midrst_after_proto_err", perr, 1'b0);
    chk("arq_drained", arq.size(), 0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
